// File: rtl/pi_spi_pkg.sv
// Shared types and constants for the Raspberry Pi SPI slave scheduler.
package pi_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'h00;

endpackage

// File: rtl/pi_spi_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo NREQ.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] next_ptr
);

  logic found;
  int   idx;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = PTR_W'((idx + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/pi_spi_sched.sv
// SPI mode-0 slave that is oversampled in the clk domain. It frames MOSI into bytes and
// round-robins NREQ byte producers onto MISO, with back-to-back bytes inside one CE frame.
module pi_spi_sched
  import pi_spi_pkg::*;
#(
  parameter int                NREQ        = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclk,
  input  logic                     pi_CE,
  input  logic                     pi_MOSI,
  output logic                     pi_MISO,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BYTE_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [BYTE_W-1:0]        rx_data,
  output logic                     rx_valid,
  output logic                     busy,
  output spi_state_t               state_dbg
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [SYNC_STAGES-1:0] sclk_sync, ce_sync, mosi_sync;
  logic                   sclk_d;
  logic                   sclk_s, ce_s, mosi_s, rise, fall;

  // CE syncs reset high (inactive), so a frame cannot start before the real pin is seen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_sync <= '0;
      ce_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ce_sync   <= {ce_sync[SYNC_STAGES-2:0], pi_CE};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], pi_MOSI};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ce_s   = ce_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;
  assign fall   = ~sclk_s & sclk_d;

  spi_state_t        state;
  logic [PTR_W-1:0]  ptr;
  logic [2:0]        count;
  logic              byte_done;
  logic [BYTE_W-1:0] tx_shift, rx_shift, rx_next, tx_pick;
  logic [NREQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]  arb_next_ptr;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req      (req),
    .ptr      (ptr),
    .gnt      (arb_gnt),
    .next_ptr (arb_next_ptr)
  );

  always_comb begin
    tx_pick = IDLE_BYTE;
    for (int k = 0; k < NREQ; k++)
      if (arb_gnt[k]) tx_pick = req_data[k*BYTE_W +: BYTE_W];
  end

  assign rx_next = {rx_shift[BYTE_W-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      count     <= '0;
      byte_done <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          count     <= '0;
          byte_done <= 1'b0;
          if (!ce_s) state <= LOAD;
        end
        LOAD: begin
          count     <= '0;
          byte_done <= 1'b0;
          if (ce_s) begin
            state <= IDLE;
          end else begin
            tx_shift <= tx_pick;
            if (|arb_gnt) ptr <= arb_next_ptr;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise) begin
            rx_shift <= rx_next;
            if (count == 3'd7) begin
              rx_data   <= rx_next;
              rx_valid  <= 1'b1;
              count     <= '0;
              byte_done <= 1'b1;
            end else begin
              count <= count + 3'd1;
            end
          end else if (fall) begin
            if (byte_done) state <= LOAD;
            else           tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
          end
          // A completing 8th rise above still lands even when CE closes the frame now.
          if (ce_s) begin
            state     <= IDLE;
            count     <= '0;
            byte_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // req/gnt: a requester holds req and req_data stable until it sees the one-cycle
  // gnt pulse, which happens in the cycle its byte is copied into tx_shift.
  assign gnt       = (state == LOAD && !ce_s) ? arb_gnt : '0;
  assign busy      = (state != IDLE);
  assign pi_MISO   = busy & tx_shift[BYTE_W-1];
  assign state_dbg = state;

endmodule

// File: doc/pi_spi_sched.md
Name: pi_spi_sched

Overview:
- System-clock-domain SPI slave controller for the Raspberry Pi link. It oversamples the Pi's sclk/CE/MOSI lines and frames the traffic into bytes.
- Acts as a round-robin scheduler: several on-FPGA requesters share the single MISO byte channel back to the Pi.
- Received bytes are delivered to the design as one-cycle strobes.
- Sits between the Pi header pins and the voltage/sample producers.

Parameters:
- NREQ, 4: number of requesters sharing the MISO channel (2..8).
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers (≥2).
- IDLE_BYTE, 8'h00: byte shifted out when no requester is pending.

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- reset  in  1  synchronous, active-low reset.
- sclk  in  1  SPI clock from Pi master (asynchronous, mode 0).
- pi_CE  in  1  SPI chip enable from Pi, active-low (asynchronous).
- pi_MOSI  in  1  master-out data (asynchronous).
- pi_MISO  out  1  slave-out data.
- req  in  NREQ  per-requester "byte pending" level.
- req_data  in  NREQ*8  packed TX bytes; requester i occupies bits [8i+7:8i].
- gnt  out  NREQ  one-hot, one-cycle pulse: the requester's byte was loaded for transmission.
- rx_data  out  8  last complete received byte.
- rx_valid  out  1  one-cycle strobe; rx_data is new.
- busy  out  1  high while a frame is active (synchronized CE low).

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE, rr pointer=0, bit count=0, shift registers=0, pi_MISO=0, gnt=0, rx_data=0, rx_valid=0, busy=0.
- Synchronizers: sclk, pi_CE and pi_MOSI each pass through SYNC_STAGES FFs. Edge detection compares the last stage with a one-cycle-delayed copy. rise = sclk 0→1, fall = sclk 1→0.
- Timing constraint: sclk period ≥ 8 clk periods. The Pi must hold CE low ≥ SYNC_STAGES+3 clk before the first sclk rise.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: busy=0, pi_MISO=0. Synchronized CE low → LOAD.
  - LOAD (exactly 1 cycle): arbitrate, load tx_shift, count=0, → SHIFT. busy=1 from this cycle.
  - SHIFT, on rise: rx_shift <= {rx_shift[6:0], MOSI_sync}; count++.
    - When count reaches 8: rx_data <= new byte, rx_valid=1 on the following cycle, count wraps to 0, set byte_done.
  - SHIFT, on fall:
    - byte_done clear: tx_shift <= {tx_shift[6:0], 0}.
    - byte_done set: → LOAD, which fetches the next byte. This supports back-to-back bytes within one CE frame.
  - Synchronized CE high in any non-IDLE state → IDLE the same cycle. A partial byte is discarded (no rx_valid), and the bit count is cleared.
- pi_MISO = tx_shift[7] while busy, else 0. This gives MSB first and changes only on fall/LOAD, so the bit is stable before the Pi's rise.
- Arbitration in LOAD:
  - Search req starting at index ptr, wrapping modulo NREQ. The first asserted index k wins.
  - On a win: tx_shift <= req_data[k], gnt[k]=1 for that cycle, ptr <= (k+1) mod NREQ.
  - No req asserted: tx_shift <= IDLE_BYTE, gnt=0, ptr unchanged.
- A byte, once granted, counts as consumed even if CE aborts mid-byte. It is not re-sent.
- Simultaneous events:
  - CE rise on the same cycle as the 8th rise: the byte completes, rx_valid is issued, then → IDLE.
  - reset overrides everything, including mid-frame.
- req is sampled only in LOAD. Requesters must hold req_data stable while req is high until gnt.

Decomposition:
- Package pi_spi_pkg:
  - typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_state_t
  - localparam BYTE_W=8
  - the IDLE_BYTE default
- One sub-module: rr_arbiter (NREQ, req, ptr in → one-hot gnt, next ptr; purely combinational), instantiated once.
- The synchronizer chain stays inline.

Test Plan:
- Reset mid-frame: assert reset during bit 4 of a byte → next cycle all outputs 0, state IDLE; the following CE frame starts cleanly.
- Single byte RX: CE low, Pi sends 0xA5 at sclk=clk/10 → exactly one rx_valid with rx_data=0xA5; busy high throughout.
- Single byte TX: req=4'b0100, req_data[23:16]=0x3C → gnt=4'b0100 for one cycle after CE falls; MISO bits sampled on 8 rises = 0,0,1,1,1,1,0,0.
- Round robin: req=4'b1011 held over 4 back-to-back bytes in one frame → grants 0,1,3,0 in that order; MISO carries each requester's byte.
- No requester: req=0, 2-byte frame → MISO=0x00,0x00, gnt never asserts, ptr unchanged.
- CE abort: raise CE after 5 rises → no rx_valid, busy drops within SYNC_STAGES+1 cycles; the next frame's first byte is fully correct.
